// File: rtl/arbiter_rr4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the FSM state encoding, requester count, select width and a one-hot decode helper.
package arbiter_rr4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int TIMER_W = 8;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_REQ-1:0] oh;
    oh    = 4'b0000;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arbiter_rr4_pick.sv
// Rotated priority encoder: first set request bit in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import arbiter_rr4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic             found_s;
  logic [SEL_W-1:0] idx_s;

  // scan requesters starting at the pointer, keep the first hit
  always_comb begin
    winner  = ptr;
    found_s = 1'b0;
    idx_s   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ptr + SEL_W'(i);
      if (!found_s && req[idx_s]) begin
        winner  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Grants are registered; back-to-back handover re-arbitrates in the ending cycle.
module arbiter_rr4
  import arbiter_rr4_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               release_i,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_MAX - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic [SEL_W-1:0]     arb_ptr_s;
  logic [SEL_W-1:0]     winner_s;
  logic                 any_s;
  logic                 grant_end_s;

  // while granting, the only arbitration that matters is the handover one, so rotate past the holder
  assign arb_ptr_s   = (state_q == ST_GRANT) ? (sel_q + 2'd1) : ptr_q;
  assign grant_end_s = (state_q == ST_GRANT) &&
                       (release_i || !req[sel_q] || (timer_q == TIMER_LAST));

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (arb_ptr_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // next-state, pointer, timer and registered output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d = ST_GRANT;
          sel_d   = winner_s;
          gnt_d   = sel_onehot(winner_s);
          timer_d = 8'd0;
        end else begin
          gnt_d   = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (grant_end_s) begin
          ptr_d = sel_q + 2'd1;
          if (any_s) begin
            sel_d   = winner_s;
            gnt_d   = sel_onehot(winner_s);
            timer_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            timer_d = 8'd0;
          end
        end else if (timer_q != TIMER_LAST) begin
          timer_d = timer_q + 8'd1;
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        timer_d = 8'd0;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      timer_q <= timer_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = (state_q == ST_GRANT);

endmodule

// File: tb/tb_arbiter_rr4.sv
// Randomized and directed bench for arbiter_rr4, checked against a cycle-level behavioural model.
module tb_arbiter_rr4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [1:0] sel15, sel1;
  logic [3:0] gnt15, gnt1;
  logic       busy15, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit busy;
    int sel;
    int ptr;
    int held;
  } model_t;

  model_t m15, m1;

  arbiter_rr4 #(.HOLD_MAX(15)) u_dut15 (
    .clk(clk), .rst(rst), .req(req), .release_i(rel),
    .sel(sel15), .gnt(gnt15), .busy(busy15)
  );

  arbiter_rr4 #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .release_i(rel),
    .sel(sel1), .gnt(gnt1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // held counts cycles the current grant has been visible, so a grant may live hmax cycles
  function automatic model_t model_step(model_t m, bit r, bit [3:0] rq, bit rl, int hmax);
    model_t n;
    bit     done;
    n = m;
    if (r) begin
      n.busy = 1'b0; n.sel = 0; n.ptr = 0; n.held = 0;
      return n;
    end
    if (m.busy) begin
      if (!(rl || !rq[m.sel] || m.held >= hmax)) begin
        n.held = m.held + 1;
        return n;
      end
      n.ptr = (m.sel + 1) % 4;
    end
    if (rq == 4'b0000) begin
      n.busy = 1'b0;
      return n;
    end
    done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!done && rq[(n.ptr + k) % 4]) begin
        n.sel = (n.ptr + k) % 4;
        done  = 1'b1;
      end
    end
    n.busy = 1'b1;
    n.held = 1;
    return n;
  endfunction

  task automatic do_cycle(input bit r, input bit [3:0] rq, input bit rl);
    @(negedge clk);
    rst = r; req = rq; rel = rl;
    m15 = model_step(m15, r, rq, rl, 15);
    m1  = model_step(m1,  r, rq, rl, 1);
    @(posedge clk);
    #1;
    check_eq("h15_busy", 32'(busy15), 32'(m15.busy));
    check_eq("h15_sel",  32'(sel15),  32'(m15.sel));
    check_eq("h15_gnt",  32'(gnt15),  m15.busy ? (32'd1 << m15.sel) : 32'd0);
    check_eq("h15_ptr",  32'(u_dut15.ptr_q), 32'(m15.ptr));
    check_eq("h1_busy",  32'(busy1),  32'(m1.busy));
    check_eq("h1_sel",   32'(sel1),   32'(m1.sel));
    check_eq("h1_gnt",   32'(gnt1),   m1.busy ? (32'd1 << m1.sel) : 32'd0);
  endtask

  initial begin
    int exp_seq[5];
    rst = 1'b1; req = 4'b0000; rel = 1'b0;
    m15 = '{busy: 1'b0, sel: 0, ptr: 0, held: 0};
    m1  = m15;

    do_cycle(1'b1, 4'b0000, 1'b0);
    do_cycle(1'b1, 4'b1111, 1'b1);
    check_eq("rst_gnt", 32'(gnt15), 32'd0);
    check_eq("rst_sel", 32'(sel15), 32'd0);

    // all requesting, release every grant: strict rotation with no bubble
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 4'b1111, 1'b1);
      check_eq("rot_sel", 32'(sel15), 32'(exp_seq[i]));
      check_eq("rot_busy", 32'(busy15), 32'd1);
    end

    // sole requester held to the limit, then re-granted
    do_cycle(1'b1, 4'b0000, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      do_cycle(1'b0, 4'b0100, 1'b0);
      check_eq("hold_gnt", 32'(gnt15), 32'h4);
    end
    check_eq("hold_ptr", 32'(u_dut15.ptr_q), 32'd3);
    check_eq("hold_timer", 32'(u_dut15.timer_q), 32'd0);

    // wrap-around from ptr=3
    do_cycle(1'b0, 4'b0101, 1'b1);
    check_eq("wrap_sel0", 32'(sel15), 32'd0);
    do_cycle(1'b0, 4'b0101, 1'b1);
    check_eq("wrap_sel2", 32'(sel15), 32'd2);

    // holder drops its request with nobody else waiting
    do_cycle(1'b1, 4'b0000, 1'b0);
    do_cycle(1'b0, 4'b0010, 1'b0);
    check_eq("drop_sel_pre", 32'(sel15), 32'd1);
    do_cycle(1'b0, 4'b0000, 1'b0);
    check_eq("drop_busy", 32'(busy15), 32'd0);
    check_eq("drop_gnt", 32'(gnt15), 32'd0);
    check_eq("drop_sel", 32'(sel15), 32'd1);

    // release while idle is ignored
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, 4'b0000, 1'b1);
      check_eq("idle_rel_busy", 32'(busy15), 32'd0);
      check_eq("idle_rel_sel", 32'(sel15), 32'd1);
    end

    // reset mid-grant to requester 3
    do_cycle(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) do_cycle(1'b0, 4'b1111, 1'b1);
    check_eq("mid_rst_pre", 32'(sel15), 32'd3);
    do_cycle(1'b1, 4'b1111, 1'b0);
    check_eq("mid_rst_gnt", 32'(gnt15), 32'd0);
    check_eq("mid_rst_busy", 32'(busy15), 32'd0);
    check_eq("mid_rst_sel", 32'(sel15), 32'd0);
    do_cycle(1'b0, 4'b1111, 1'b0);
    check_eq("post_rst_sel", 32'(sel15), 32'd0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      do_cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
               4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    // sticky requests with rare release to exercise the hold limit
    for (int c = 0; c < 1000; c++) begin
      do_cycle(1'b0,
               ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b1011,
               ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
